cell_writer: RTL and testbench

//  Writes one cell of the arena: read-modify-write of a single bit in one arena
//  row over the arena's synchronous port B. It is the write-side counterpart of

---
 rtl/cell_writer.sv | 114 +++++++++++
 tb/tb_cell_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cell_writer.sv
// Read-modify-write of a single arena cell over the arena's synchronous port B.
// Supports forced set/clear and in-place toggle; one operation every four cycles.
module cell_writer #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [9:0]             cell_column,
    input  logic [9:0]             cell_row,
    input  logic                   cell_value,
    input  logic                   cell_toggle,
    output logic                   range_error,
    output logic [9:0]             arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns,
    output logic [ARENA_WIDTH-1:0] arena_columns_out,
    output logic                   arena_write
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        MODIFY = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [9:0] COL_LIMIT = 10'(ARENA_WIDTH);
    localparam logic [9:0] ROW_LIMIT = 10'(ARENA_HEIGHT);

    state_t                 state_q, state_d;
    logic                   ready_q;
    logic                   range_err_q;
    logic [9:0]             col_q;
    logic [9:0]             row_q;
    logic                   val_q;
    logic                   tog_q;
    logic [ARENA_WIDTH-1:0] new_row_q, new_row_d;
    logic                   accept;
    logic                   in_range;
    logic [ARENA_WIDTH-1:0] mask;

    assign accept   = start && ready_q;
    assign in_range = (cell_column < COL_LIMIT) && (cell_row < ROW_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && in_range) state_d = READ;
            READ:    state_d = MODIFY;
            MODIFY:  state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arena_write       = (state_q == WRITE);
        ready             = ready_q;
        range_error       = range_err_q;
        arena_row_select  = row_q;
        arena_columns_out = new_row_q;
    end

    always_comb begin
        mask = {{(ARENA_WIDTH-1){1'b0}}, 1'b1} << col_q;
        if (tog_q) begin
            new_row_d = arena_columns ^ mask;
        end else if (val_q) begin
            new_row_d = arena_columns | mask;
        end else begin
            new_row_d = arena_columns & ~mask;
        end
    end

    // Target is only captured for in-range requests, so the RAM is never
    // addressed with a row it does not have.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q     <= 1'b1;
            range_err_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            val_q       <= 1'b0;
            tog_q       <= 1'b0;
            new_row_q   <= '0;
        end else begin
            range_err_q <= accept && !in_range;
            if (accept && in_range) begin
                col_q   <= cell_column;
                row_q   <= cell_row;
                val_q   <= cell_value;
                tog_q   <= cell_toggle;
                ready_q <= 1'b0;
            end
            if (state_q == MODIFY) begin
                new_row_q <= new_row_d;
            end
            if (state_q == WRITE) begin
                ready_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cell_writer.sv
// Bench for cell_writer: a 10x10 arena RAM model on port B, a table of single
// requests with hand-computed row results, then streaming and abort sequences.
module tb_cell_writer;
    localparam int W = 10;
    localparam int H = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [9:0]   cell_column;
    logic [9:0]   cell_row;
    logic         cell_value;
    logic         cell_toggle;
    logic         range_error;
    logic [9:0]   arena_row_select;
    logic [W-1:0] arena_columns;
    logic [W-1:0] arena_columns_out;
    logic         arena_write;

    always #2 clk = ~clk;

    cell_writer #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .ready             (ready),
        .cell_column       (cell_column),
        .cell_row          (cell_row),
        .cell_value        (cell_value),
        .cell_toggle       (cell_toggle),
        .range_error       (range_error),
        .arena_row_select  (arena_row_select),
        .arena_columns     (arena_columns),
        .arena_columns_out (arena_columns_out),
        .arena_write       (arena_write)
    );

    // Arena RAM model: registered read, write on the same edge.
    logic [W-1:0] mem [0:H-1];
    logic         clr;
    logic         pre_en;
    logic [3:0]   pre_row;
    logic [W-1:0] pre_val;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < H; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_row] <= pre_val;
        end else if (arena_write && arena_row_select < 10'(H)) begin
            mem[arena_row_select[3:0]] <= arena_columns_out;
        end
        if (arena_row_select < 10'(H)) arena_columns <= mem[arena_row_select[3:0]];
    end

    typedef struct {
        bit         pre;
        logic [9:0] pre_val;
        logic [9:0] col;
        logic [9:0] row;
        bit         val;
        bit         tog;
        bit         err;
        logic [9:0] exp;
    } vec_t;

    vec_t         tbl [12];
    logic [W-1:0] exp_mem [0:H-1];
    int           nvec = 0;
    int           nfail = 0;

    function automatic vec_t mk(bit pre, logic [9:0] pv, logic [9:0] c, logic [9:0] r,
                                bit v, bit t, bit e, logic [9:0] x);
        vec_t o;
        o.pre = pre; o.pre_val = pv; o.col = c; o.row = r;
        o.val = v; o.tog = t; o.err = e; o.exp = x;
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] r, input logic [W-1:0] v);
        @(negedge clk);
        pre_row = r; pre_val = v; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        exp_mem[r] = v;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int err_cnt, wr_cnt, wr_idx, bad_rows;
        logic [W-1:0] wr_out;
        err_cnt = 0; wr_cnt = 0; wr_idx = -1; wr_out = '0;
        if (v.pre) preload(v.row[3:0], v.pre_val);
        @(negedge clk);
        check($sformatf("v%0d ready_before", idx), int'(ready), 1);
        cell_column = v.col; cell_row = v.row; cell_value = v.val; cell_toggle = v.tog;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cell_column = 10'($urandom); cell_row = 10'($urandom);
        cell_value = 1'($urandom); cell_toggle = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("v%0d ready_after_accept", idx), int'(ready), v.err ? 1 : 0);
            if (range_error) err_cnt++;
            if (arena_write) begin
                wr_cnt++; wr_idx = k; wr_out = arena_columns_out;
            end
        end
        check($sformatf("v%0d range_error_pulses", idx), err_cnt, v.err ? 1 : 0);
        check($sformatf("v%0d write_pulses", idx), wr_cnt, v.err ? 0 : 1);
        if (!v.err) begin
            check($sformatf("v%0d write_cycle", idx), wr_idx, 2);
            check($sformatf("v%0d columns_out", idx), int'(wr_out), int'(v.exp));
            exp_mem[v.row[3:0]] = v.exp;
        end
        check($sformatf("v%0d ready_end", idx), int'(ready), 1);
        bad_rows = 0;
        for (int i = 0; i < H; i++) if (mem[i] !== exp_mem[i]) bad_rows++;
        check($sformatf("v%0d arena_rows_wrong", idx), bad_rows, 0);
    endtask

    initial begin
        int n_wr, n_acc, last_acc, wr_seen;
        bit acc;

        tbl[0]  = mk(0, 10'h000, 10'd3,    10'd0,    1, 0, 0, 10'h008);
        tbl[1]  = mk(0, 10'h000, 10'd9,    10'd9,    0, 1, 0, 10'h200);
        tbl[2]  = mk(0, 10'h000, 10'd9,    10'd9,    1, 1, 0, 10'h000);
        tbl[3]  = mk(1, 10'h3FF, 10'd9,    10'd4,    0, 0, 0, 10'h1FF);
        tbl[4]  = mk(0, 10'h000, 10'd10,   10'd0,    1, 0, 1, 10'h000);
        tbl[5]  = mk(0, 10'h000, 10'd0,    10'd10,   1, 0, 1, 10'h000);
        tbl[6]  = mk(0, 10'h000, 10'd0,    10'd0,    0, 1, 0, 10'h009);
        tbl[7]  = mk(0, 10'h000, 10'd3,    10'd0,    0, 0, 0, 10'h001);
        tbl[8]  = mk(0, 10'h000, 10'd9,    10'd9,    1, 0, 0, 10'h200);
        tbl[9]  = mk(0, 10'h000, 10'd5,    10'd7,    0, 0, 0, 10'h000);
        tbl[10] = mk(0, 10'h000, 10'd1023, 10'd1023, 1, 0, 1, 10'h000);
        tbl[11] = mk(0, 10'h000, 10'd9,    10'd4,    0, 1, 0, 10'h3FF);

        for (int i = 0; i < H; i++) exp_mem[i] = '0;
        reset = 1'b1; clr = 1'b1; start = 1'b0; pre_en = 1'b0; pre_row = '0; pre_val = '0;
        cell_column = '0; cell_row = '0; cell_value = 1'b0; cell_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; clr = 1'b0;
        @(negedge clk);
        check("reset ready", int'(ready), 1);
        check("reset range_error", int'(range_error), 0);
        check("reset arena_write", int'(arena_write), 0);
        check("reset row_select", int'(arena_row_select), 0);
        check("reset columns_out", int'(arena_columns_out), 0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // Streaming: start held high, column advanced on every acceptance.
        @(negedge clk);
        cell_row = 10'd2; cell_value = 1'b1; cell_toggle = 1'b0; cell_column = 10'd0;
        start = 1'b1;
        n_wr = 0; n_acc = 0; last_acc = -1;
        for (int cyc = 0; cyc < 60 && n_wr < 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (arena_write) begin
                check($sformatf("stream write%0d columns_out", n_wr),
                      int'(arena_columns_out), (2 << n_wr) - 1);
                n_wr++;
            end
            acc = ready && start;
            @(posedge clk);
            #1;
            if (acc) begin
                if (last_acc >= 0) check($sformatf("stream accept%0d spacing", n_acc), cyc - last_acc, 4);
                last_acc = cyc;
                n_acc++;
                cell_column = cell_column + 10'd1;
                if (n_acc == 10) start = 1'b0;
            end
        end
        check("stream accepts", n_acc, 10);
        check("stream writes", n_wr, 10);
        repeat (2) @(negedge clk);
        check("stream row2", int'(mem[2]), 10'h3FF);
        exp_mem[2] = 10'h3FF;

        // Abort: reset lands while the FSM is in MODIFY.
        preload(4'd6, 10'h055);
        @(negedge clk);
        cell_column = 10'd1; cell_row = 10'd6; cell_value = 1'b1; cell_toggle = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort ready", int'(ready), 1);
        check("abort arena_write", int'(arena_write), 0);
        check("abort row_select", int'(arena_row_select), 0);
        check("abort columns_out", int'(arena_columns_out), 0);
        reset = 1'b0;
        wr_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (arena_write) wr_seen++;
        end
        check("abort writes_after", wr_seen, 0);
        check("abort row6", int'(mem[6]), 10'h055);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
